// File: rtl/alu_pkg.sv
// Shared definitions for the execution unit: opcodes, FSM states,
// NZCV flag bit positions and the iterative multiplier length.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_ORR = 3'd3,
    OP_EOR = 3'd4,
    OP_MOV = 3'd5,
    OP_MUL = 3'd6,
    OP_NOP = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Bit positions inside the 4-bit NZCV flag vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // One multiplier bit is consumed per cycle.
  localparam int MUL_CYCLES = 32;

endpackage : alu_pkg

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: retires one multiplier bit per cycle and
// produces the low WIDTH bits of a*b after CYCLES cycles. done is asserted
// during the final iteration, with product already including that step.
module mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CYCLES = MUL_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic             busy;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             last;

  // Partial-product add for the current multiplier bit.
  always_comb begin
    acc_next = acc + (multiplier[0] ? multiplicand : '0);
  end

  assign last    = (cnt == CW'(CYCLES - 1));
  assign done    = busy && last;
  assign product = acc_next;

  // Load operands on start, then shift multiplicand left and multiplier
  // right each cycle until the final bit has been accumulated.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy         <= 1'b0;
      cnt          <= '0;
      acc          <= '0;
      multiplicand <= '0;
      multiplier   <= '0;
    end else if (start) begin
      busy         <= 1'b1;
      cnt          <= '0;
      acc          <= '0;
      multiplicand <= a;
      multiplier   <= b;
    end else if (busy) begin
      acc          <= acc_next;
      multiplicand <= multiplicand << 1;
      multiplier   <= multiplier >> 1;
      cnt          <= cnt + CW'(1);
      if (last) begin
        busy <= 1'b0;
      end
    end
  end

endmodule : mul_iter

// File: rtl/exec_unit.sv
// Execution unit: accepts an op/operand bundle on a valid/ready handshake,
// computes the ALU result and NZCV flags (single cycle, or iteratively for
// MUL), holds the result until downstream takes it, and drives the
// register-file write port on that handshake.
module exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       dest,
  input  logic             wb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic [3:0]       write_addr,
  output logic [WIDTH-1:0] write_data,
  output logic             wr_en
);

  state_e           state;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic [3:0]       dest_q;
  logic             wb_q;

  logic             accept;
  logic             is_mul;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             alu_wb;
  logic [3:0]       alu_flags;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [3:0]       mul_flags;

  // A new bundle may enter when idle, or when the held result leaves this cycle.
  assign in_ready = !reset && ((state == S_IDLE) || (state == S_DONE && out_ready));
  assign accept   = in_valid && in_ready;
  assign is_mul   = (op_e'(op) == OP_MUL);

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // Single-cycle ALU and NZCV flags from the presented operands.
  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_wb  = wb;
    case (op_e'(op))
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = !diff[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_ORR:  alu_res = a | b;
      OP_EOR:  alu_res = a ^ b;
      OP_MOV:  alu_res = b;
      OP_MUL:  alu_res = '0;
      default: alu_wb  = 1'b0;
    endcase
    alu_flags         = '0;
    alu_flags[FLAG_N] = alu_res[WIDTH-1];
    alu_flags[FLAG_Z] = (alu_res == '0);
    alu_flags[FLAG_C] = alu_c;
    alu_flags[FLAG_V] = alu_v;
  end

  // MUL only reports N and Z; C and V stay clear.
  always_comb begin
    mul_flags         = '0;
    mul_flags[FLAG_N] = mul_product[WIDTH-1];
    mul_flags[FLAG_Z] = (mul_product == '0);
  end

  mul_iter #(
    .WIDTH  (WIDTH),
    .CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (accept && is_mul),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  // Control FSM with registered result, flags and write-back target.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      result_q <= '0;
      flags_q  <= '0;
      dest_q   <= '0;
      wb_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            dest_q <= dest;
            wb_q   <= alu_wb;
            if (is_mul) begin
              state <= S_BUSY;
            end else begin
              state    <= S_DONE;
              result_q <= alu_res;
              flags_q  <= alu_flags;
            end
          end else if (state == S_DONE && out_ready) begin
            state <= S_IDLE;
          end
        end
        S_BUSY: begin
          if (mul_done) begin
            state    <= S_DONE;
            result_q <= mul_product;
            flags_q  <= mul_flags;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign out_valid  = (state == S_DONE);
  assign result     = result_q;
  assign flags      = flags_q;
  assign write_addr = dest_q;
  assign write_data = result_q;
  assign wr_en      = out_valid && out_ready && wb_q;

endmodule : exec_unit

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter: WIDTH, 32, datapath width of operands and result.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand/op bundle presented by upstream.
REQ-005 in_ready  output  1  exec_unit can accept a bundle this cycle.
REQ-006 op  input  3  operation code from alu_pkg.
REQ-007 a, b  input  WIDTH each  operands, driven by register-file read_data1/read_data2.
REQ-008 dest  input  4  destination register index.
REQ-009 wb  input  1  result is to be written back.
REQ-010 out_valid  output  1  result bundle valid.
REQ-011 out_ready  input  1  downstream accepts the result (low = stall).
REQ-012 result  output  WIDTH  computed value.
REQ-013 flags  output  4  NZCV, bit3=N, bit0=V.
REQ-014 write_addr, write_data, wr_en  output  4/WIDTH/1  register-file write port.

Function
REQ-015 Bundle is accepted in a cycle where in_valid && in_ready is high; a, b, op, dest and wb are captured at that edge.
REQ-016 Ops: ADD=a+b, SUB=a-b, AND, ORR, EOR, MOV=b, MUL=low WIDTH bits of a*b, NOP=result 0 with wb forced 0.
REQ-017 Flags: N=result[WIDTH-1]; Z=(result==0); ADD: C=carry out, V=signed overflow; SUB: C=not-borrow (a>=b unsigned), V=signed overflow; all other ops: C=0, V=0.
REQ-018 FSM states: IDLE, BUSY, DONE.
REQ-019 IDLE: accept of a non-MUL op -> DONE; accept of MUL -> BUSY.
REQ-020 BUSY runs an iterative shift-add multiply for exactly 32 cycles and then moves to DONE.
REQ-021 Latency: a non-MUL op accepted at edge T shows out_valid=1 after edge T+1; a MUL op shows it after edge T+33.
REQ-022 DONE: out_valid=1; result, flags, write_addr and write_data stay stable until out_valid && out_ready.
REQ-023 in_ready = (state==IDLE) || (state==DONE && out_ready); in BUSY, in_ready=0.
REQ-024 DONE with out_ready=1 and no new accept -> IDLE; DONE with out_ready=1 and a new accept -> DONE (non-MUL) or BUSY (MUL), giving back-to-back throughput of one non-MUL op per cycle.
REQ-025 wr_en = out_valid && out_ready && wb_captured; write_addr=dest_captured; write_data=result.
REQ-026 Arithmetic wraps modulo 2^WIDTH; a multiply result with no bits set in its low WIDTH bits yields Z=1.
REQ-027 Undefined op encodings behave as NOP.

Reset
REQ-028 When reset is high at a rising edge: state=IDLE; out_valid=0, wr_en=0, result=0, flags=0, write_addr=0; multiplier counter and accumulator cleared.
REQ-029 Reset during BUSY or DONE aborts the operation; no wr_en pulse is produced for it.
REQ-030 in_ready=0 while reset is high; in_ready=1 in the first cycle after reset deasserts.

Structure
REQ-031 Package alu_pkg holds the op enum (ADD=0, SUB, AND, ORR, EOR, MOV, MUL, NOP=7), the FSM state enum, the NZCV bit-index constants and MUL_CYCLES=32.
REQ-032 Sub-module mul_iter holds the shift-add multiplier (start, a, b, done, product), one bit per cycle.
REQ-033 The combinational ALU and flag logic live in exec_unit.

Verification
REQ-034 ADD a=0x7FFFFFFF, b=0x00000001 -> result=0x80000000, flags=1001, out_valid one cycle after accept.
REQ-035 SUB a=5, b=5, dest=3, wb=1, out_ready=1 -> result=0, flags=0110; wr_en pulses once with write_addr=3, write_data=0.
REQ-036 MUL a=0xFFFFFFFF, b=0xFFFFFFFF -> result=0x00000001, flags=0000; out_valid asserts 33 cycles after accept; in_ready=0 throughout BUSY.
REQ-037 Hold out_ready=0 for 5 cycles after AND 0xF0F0F0F0 & 0x0FF00FF0 -> result=0x00F000F0 held stable; wr_en=0 until out_ready rises.
REQ-038 Reset asserted at BUSY cycle 10 of a MUL -> IDLE next cycle, out_valid=0, no wr_en; a following ADD 2+3 returns 5.
REQ-039 Stream 4 back-to-back ADDs with out_ready=1 -> 4 consecutive out_valid cycles and 4 wr_en pulses in order.
